// File: rtl/lfsr_decrypt_seq.sv
// Sequencer for the LFSR decrypt datapath. Loads the bank of 6 LFSRs, trains a
// candidate mask on a known preamble, picks the matching LFSR (highest index wins),
// then streams decrypted bytes into dat_mem.
// Ports:
//   clk, init (sync active-high reset), start (1-cycle pass request)
//   data_out   : dat_mem read data for raddr (combinational, same cycle)
//   lfsr_state : 6 x 5-bit LFSR states, LFSR i at [5i+4:5i]
//   raddr, waddr, wr_en, data_in : dat_mem control/data
//   load_lfsr, lfsr_en : LFSR bank init/advance
//   sel, busy, done, error : pass result/status
module lfsr_decrypt_seq #(
  parameter logic [7:0]  RD_BASE  = 8'd64,
  parameter logic [7:0]  WR_BASE  = 8'd0,
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned PRE_LEN  = 7,
  parameter logic [7:0]  PRE_CHAR = 8'h5F
) (
  input  logic        clk,
  input  logic        init,
  input  logic        start,
  input  logic [7:0]  data_out,
  input  logic [29:0] lfsr_state,
  output logic [7:0]  raddr,
  output logic [7:0]  waddr,
  output logic        wr_en,
  output logic [7:0]  data_in,
  output logic        load_lfsr,
  output logic        lfsr_en,
  output logic [2:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned N_LFSR = 6;
  localparam int unsigned LW     = 5;
  localparam int unsigned CNT_W  = 9;
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MSG_LEN - PRE_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_TRAIN, ST_RUN, ST_FIN, ST_FAIL
  } state_t;

  state_t             state, state_n;
  logic [7:0]         raddr_n, waddr_n;
  logic               wr_en_n, load_n, en_n, busy_n, done_n, error_n;
  logic [2:0]         sel_n;
  logic [N_LFSR-1:0]  cand, cand_n, match, mask;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LW-1:0]      key;

  // Per-LFSR preamble match on the current byte, and keystream of the selected LFSR
  always_comb begin
    match = '0;
    key   = '0;
    for (int i = 0; i < int'(N_LFSR); i++) begin
      match[i] = ((data_out ^ {3'b000, lfsr_state[LW*i +: LW]}) == PRE_CHAR);
      if (sel == 3'(i)) key = lfsr_state[LW*i +: LW];
    end
  end

  assign mask    = cand & match;
  assign data_in = (state == ST_RUN) ? (data_out ^ {3'b000, key}) : 8'h00;

  // Next-state and next registered-output logic
  always_comb begin
    state_n = state;
    raddr_n = raddr;
    waddr_n = waddr;
    cand_n  = cand;
    sel_n   = sel;
    cnt_n   = cnt;
    done_n  = done;
    error_n = error;
    wr_en_n = 1'b0;
    load_n  = 1'b0;
    en_n    = 1'b0;
    busy_n  = 1'b0;
    case (state)
      ST_IDLE, ST_FIN, ST_FAIL: begin
        if (start) begin
          state_n = ST_LOAD;
          raddr_n = RD_BASE;
          waddr_n = WR_BASE;
          cand_n  = '1;
          cnt_n   = '0;
          done_n  = 1'b0;
          error_n = 1'b0;
          load_n  = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_n = ST_TRAIN;
        raddr_n = RD_BASE;
        cnt_n   = '0;
        en_n    = 1'b1;
        busy_n  = 1'b1;
      end
      ST_TRAIN: begin
        cand_n = mask;
        if (cnt == TRAIN_LAST) begin
          cnt_n = '0;
          if (mask == '0) begin
            state_n = ST_FAIL;
            done_n  = 1'b1;
            error_n = 1'b1;
          end else begin
            // Highest set bit wins
            for (int i = 0; i < int'(N_LFSR); i++) begin
              if (mask[i]) sel_n = 3'(i);
            end
            state_n = ST_RUN;
            raddr_n = raddr + 8'd1;
            wr_en_n = 1'b1;
            en_n    = 1'b1;
            busy_n  = 1'b1;
          end
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          raddr_n = raddr + 8'd1;
          en_n    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt == RUN_LAST) begin
          state_n = ST_FIN;
          done_n  = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          raddr_n = raddr + 8'd1;
          waddr_n = waddr + 8'd1;
          wr_en_n = 1'b1;
          en_n    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (init) begin
      state     <= ST_IDLE;
      raddr     <= RD_BASE;
      waddr     <= WR_BASE;
      wr_en     <= 1'b0;
      load_lfsr <= 1'b0;
      lfsr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      sel       <= '0;
      cand      <= '1;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      raddr     <= raddr_n;
      waddr     <= waddr_n;
      wr_en     <= wr_en_n;
      load_lfsr <= load_n;
      lfsr_en   <= en_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      sel       <= sel_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// Scoreboard bench for lfsr_decrypt_seq: two instances (RD_BASE 64 and 224), each
// with its own encrypted image and LFSR bank. Expected writes are queued from a
// keystream-level reference model; a monitor pops them as the DUTs write.
module tb_lfsr_decrypt_seq;

  localparam int MSG_LEN = 64;
  localparam int PRE_LEN = 7;
  localparam logic [7:0] PRE_CHAR = 8'h5F;

  logic        clk;
  logic        init      [2];
  logic        start     [2];
  logic [7:0]  data_out  [2];
  logic [29:0] lfsr_state[2];
  logic [7:0]  raddr     [2];
  logic [7:0]  waddr     [2];
  logic [7:0]  data_in   [2];
  logic        wr_en     [2];
  logic        load_lfsr [2];
  logic        lfsr_en   [2];
  logic [2:0]  sel       [2];
  logic        busy      [2];
  logic        done      [2];
  logic        error     [2];

  logic [7:0]  img  [2][256];
  logic [4:0]  lfsr [2][6];
  logic [4:0]  taps [6];
  logic [4:0]  seed [6];

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  function automatic logic [7:0] rd_base(int g);
    return (g == 0) ? 8'd64 : 8'd224;
  endfunction

  function automatic logic [7:0] wr_base(int g);
    return (g == 0) ? 8'd0 : 8'd64;
  endfunction

  function automatic logic [4:0] lfsr_next(logic [4:0] s, logic [4:0] t);
    return {s[3:0], ^(s & t)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_env
    lfsr_decrypt_seq #(
      .RD_BASE (g == 0 ? 8'd64 : 8'd224),
      .WR_BASE (g == 0 ? 8'd0  : 8'd64),
      .MSG_LEN (MSG_LEN),
      .PRE_LEN (PRE_LEN),
      .PRE_CHAR(PRE_CHAR)
    ) u_dut (
      .clk       (clk),
      .init      (init[g]),
      .start     (start[g]),
      .data_out  (data_out[g]),
      .lfsr_state(lfsr_state[g]),
      .raddr     (raddr[g]),
      .waddr     (waddr[g]),
      .wr_en     (wr_en[g]),
      .data_in   (data_in[g]),
      .load_lfsr (load_lfsr[g]),
      .lfsr_en   (lfsr_en[g]),
      .sel       (sel[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .error     (error[g])
    );

    assign data_out[g]   = img[g][raddr[g]];
    assign lfsr_state[g] = {lfsr[g][5], lfsr[g][4], lfsr[g][3],
                            lfsr[g][2], lfsr[g][1], lfsr[g][0]};

    always @(posedge clk) begin
      for (int i = 0; i < 6; i++) begin
        if (load_lfsr[g])    lfsr[g][i] <= seed[i];
        else if (lfsr_en[g]) lfsr[g][i] <= lfsr_next(lfsr[g][i], taps[i]);
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr_en[g]) begin
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write inst=%0d got addr=%0d data=%02h, required no write",
                   g, waddr[g], data_in[g]);
        end else begin
          e = exp_q.pop_front();
          writes_seen++;
          if ({waddr[g], data_in[g]} !== e) begin
            errors++;
            $display("FAIL write_data inst=%0d got addr=%0d data=%02h, required addr=%0d data=%02h",
                     g, waddr[g], data_in[g], e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: encrypt a random message with LFSR key_idx, then derive
  // the expected selection and written plaintext from the preamble rule.
  task automatic prepare(input int g, input int key_idx, input bit corrupt,
                         output int exp_cyc, output bit exp_err, output logic [2:0] exp_sel);
    logic [4:0] ks [6][MSG_LEN];
    logic [7:0] enc[MSG_LEN];
    logic [7:0] pt;
    logic [4:0] s;
    bit found;
    for (int i = 0; i < 6; i++) begin
      s = seed[i];
      for (int n = 0; n < MSG_LEN; n++) begin
        ks[i][n] = s;
        s = lfsr_next(s, taps[i]);
      end
    end
    for (int n = 0; n < MSG_LEN; n++) begin
      pt = (n < PRE_LEN) ? PRE_CHAR : 8'($urandom);
      enc[n] = pt ^ {3'b000, ks[key_idx][n]};
      if (corrupt && n == 3) enc[n] = enc[n] ^ 8'h80;
      img[g][8'(rd_base(g) + 8'(n))] = enc[n];
    end
    found = 1'b0;
    exp_sel = 3'd0;
    for (int i = 0; i < 6; i++) begin
      bit ok = 1'b1;
      for (int n = 0; n < PRE_LEN; n++)
        if ((enc[n] ^ {3'b000, ks[i][n]}) != PRE_CHAR) ok = 1'b0;
      if (ok) begin
        found = 1'b1;
        exp_sel = 3'(i);
      end
    end
    exp_err = !found;
    exp_cyc = found ? MSG_LEN + 2 : PRE_LEN + 2;
    exp_q.delete();
    if (found)
      for (int j = 0; j < MSG_LEN - PRE_LEN; j++)
        exp_q.push_back({8'(wr_base(g) + 8'(j)),
                         enc[PRE_LEN + j] ^ {3'b000, ks[exp_sel][PRE_LEN + j]}});
  endtask

  task automatic issue_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
  endtask

  // Count cycles after the start edge until done; optionally pulse start mid-pass
  task automatic wait_done(input int g, input int cyc0, input int exp_cyc, input bit exp_err,
                           input logic [2:0] exp_sel, input int busy_pulse);
    int cyc = cyc0;
    bit seen = 1'b0;
    while (cyc < 400 && !seen) begin
      @(negedge clk);
      cyc++;
      start[g] = (cyc == busy_pulse);
      if (cyc == 1) chk("load_cycle1", {31'd0, load_lfsr[g]}, 32'd1);
      if (done[g]) seen = 1'b1;
    end
    start[g] = 1'b0;
    chk("done_cycle", cyc, exp_cyc);
    chk("error", {31'd0, error[g]}, {31'd0, exp_err});
    chk("busy_at_done", {31'd0, busy[g]}, 32'd0);
    if (!exp_err) chk("sel", {29'd0, sel[g]}, {29'd0, exp_sel});
    chk("writes_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    int ec;
    bit ee;
    logic [2:0] es;
    taps = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};
    for (int i = 0; i < 6; i++) seed[i] = 5'h01;
    for (int g = 0; g < 2; g++) begin
      init[g] = 1'b1;
      start[g] = 1'b0;
      for (int a = 0; a < 256; a++) img[g][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_raddr", {24'd0, raddr[g]}, {24'd0, rd_base(g)});
      chk("rst_waddr", {24'd0, waddr[g]}, {24'd0, wr_base(g)});
      chk("rst_flags", {26'd0, wr_en[g], load_lfsr[g], lfsr_en[g], busy[g], done[g], error[g]}, 32'd0);
      chk("rst_sel", {29'd0, sel[g]}, 32'd0);
    end
    init[0] = 1'b0;
    init[1] = 1'b0;

    // Known taps 5'h1B from seed 1
    prepare(0, 2, 1'b0, ec, ee, es);
    issue_start(0);
    wait_done(0, 0, ec, ee, es, -1);

    // Corrupted preamble byte 3 -> no match
    prepare(0, 2, 1'b1, ec, ee, es);
    issue_start(0);
    wait_done(0, 0, ec, ee, es, -1);
    chk("fail_error", {31'd0, error[0]}, 32'd1);

    // LFSRs 1 and 4 share a tap pattern so both match; highest index wins
    taps[4] = taps[1];
    prepare(0, 1, 1'b0, ec, ee, es);
    issue_start(0);
    wait_done(0, 0, ec, ee, es, -1);
    chk("dual_sel4", {29'd0, sel[0]}, 32'd4);
    taps[4] = 5'h14;

    // init during RUN at j=10 (cycle 19)
    prepare(0, 3, 1'b0, ec, ee, es);
    writes_seen = 0;
    issue_start(0);
    repeat (19) @(negedge clk);
    init[0] = 1'b1;
    @(negedge clk);
    init[0] = 1'b0;
    chk("abort_writes", writes_seen, 32'd11);
    chk("abort_flags", {29'd0, wr_en[0], busy[0], done[0]}, 32'd0);
    chk("abort_raddr", {24'd0, raddr[0]}, {24'd0, rd_base(0)});
    chk("abort_waddr", {24'd0, waddr[0]}, {24'd0, wr_base(0)});
    exp_q.delete();
    prepare(0, 3, 1'b0, ec, ee, es);
    issue_start(0);
    wait_done(0, 0, ec, ee, es, -1);

    // start together with init is ignored (from FIN)
    @(negedge clk);
    start[0] = 1'b1;
    init[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    init[0] = 1'b0;
    @(negedge clk);
    chk("init_wins", {29'd0, busy[0], load_lfsr[0], done[0]}, 32'd0);

    // start pulsed while busy (cycle 5, TRAIN) is ignored
    prepare(0, 0, 1'b0, ec, ee, es);
    issue_start(0);
    wait_done(0, 0, ec, ee, es, 5);

    // start held in FIN: new pass, done drops in LOAD
    prepare(0, 5, 1'b0, ec, ee, es);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    chk("held_done_low", {31'd0, done[0]}, 32'd0);
    chk("held_load", {31'd0, load_lfsr[0]}, 32'd1);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 2, ec, ee, es, -1);

    // Read address wrap on the RD_BASE=224 instance
    prepare(1, 2, 1'b0, ec, ee, es);
    issue_start(1);
    wait_done(1, 0, ec, ee, es, -1);

    // Randomized passes: random seeds, key and instance
    for (int r = 0; r < 4; r++) begin
      int g = int'($urandom_range(1, 0));
      for (int i = 0; i < 6; i++) seed[i] = 5'($urandom_range(31, 1));
      prepare(g, int'($urandom_range(5, 0)), ($urandom_range(3, 0) == 0), ec, ee, es);
      issue_start(g);
      wait_done(g, 0, ec, ee, es, -1);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
